pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Generates the write enables and clears for the PC, the IF/ID pipeline register and the ID/EX pipeline register.
- Detects Tuse/Tnew data hazards and sequences the multi-cycle multiply/divide unit with an internal busy counter.
- Forwards the CP0 exception request as the global pipeline flush `req`; on `req`, every pipeline register flushes and the PC is redirected to 0x0000_4180.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu after the start cycle.
- DIV_CYCLES, 10: busy cycles for div/divu after the start cycle.
- CNT_W, 32: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rs_d  in  5  rs field of the instruction in D
- rt_d  in  5  rt field of the instruction in D
- tuse_rs_d  in  2  Tuse of rs; 3 = not used
- tuse_rt_d  in  2  Tuse of rt; 3 = not used
- md_d  in  1  instruction in D accesses the MDU/HI/LO (mult*, div*, mf*, mt*)
- a_e  in  5  destination register of the instruction in E; 0 = none
- tnew_e  in  2  Tnew of the instruction in E
- a_m  in  5  destination register of the instruction in M; 0 = none
- tnew_m  in  2  Tnew of the instruction in M
- md_start_e  in  1  mult/multu/div/divu in E this cycle
- md_div_e  in  1  the E-stage MDU operation is a divide
- exc_req  in  1  CP0 takes an exception/interrupt this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- idex_clr  out  1  insert a bubble into ID/EX
- req  out  1  global flush; PC goes to 0x4180
- md_busy  out  1  MDU is computing
- stall  out  1  D-stage stall this cycle
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. All state updates on posedge clk.
- Reset: md_cnt=0, md_busy=0, stall_cnt=0. While reset is high, combinational outputs are forced: req=0, stall=0, pc_we=1, ifid_we=1, idex_clr=0.
- Data hazard on rs (combinational): `h_rs = (rs_d != 0) && ((a_e == rs_d && tnew_e > tuse_rs_d) || (a_m == rs_d && tnew_m > tuse_rs_d))`.
- Data hazard on rt: `h_rt` is defined the same way using rt_d and tuse_rt_d.
- A match against register 0 never stalls.
- MDU hazard: `h_md = md_d && (md_busy || md_start_e)`.
- Stall: `stall = (h_rs | h_rt | h_md) & ~req`.
- Flush: `req = exc_req & ~reset`.
- Output equations:
  - pc_we = ~stall
  - ifid_we = ~stall
  - idex_clr = stall
  - When req is high, all three are forced to the non-stall values; `req` itself flushes the pipeline.
- MDU counter, two states:
  - IDLE (md_cnt=0): if md_start_e & ~exc_req, load md_cnt with DIV_CYCLES when md_div_e=1, else MULT_CYCLES; go to BUSY.
  - BUSY: md_cnt decrements by 1 each cycle; return to IDLE when md_cnt reaches 0.
  - md_busy = (md_cnt != 0), registered. It first goes high the cycle after the start cycle and stays high for exactly N cycles.
  - md_start_e while BUSY is ignored (the D-stage stall prevents it; the assertion is bench-checked).
  - exc_req in the same cycle as md_start_e suppresses the start. An operation already in BUSY continues to completion regardless of exc_req.
- Stall counter: stall_cnt increments by 1 on each cycle with stall=1. It saturates at all-ones and does not wrap.
- Reset mid-operation: md_cnt is cleared immediately; md_busy=0 on the next cycle.

Test Plan:
1. Load-use: a_e=5, tnew_e=2, rs_d=5, tuse_rs_d=1 -> stall=1, pc_we=0, ifid_we=0, idex_clr=1. Next cycle a_e=0, a_m=5, tnew_m=1 -> stall=0.
2. Register 0: a_e=0, rs_d=0, tnew_e=2, tuse_rs_d=0 -> stall=0. No forwarding-sensitive stall with tnew_e=0.
3. mult then mflo: md_start_e=1, md_div_e=0 at cycle t -> md_busy high for t+1..t+5, low at t+6. md_d=1 during t..t+5 -> stall=1; stall=0 at t+6.
4. div: md_div_e=1 -> md_busy high for exactly 10 cycles. Also check that exc_req=1 concurrent with md_start_e leaves md_busy=0.
5. Exception during stall: h_rs active and exc_req=1 -> req=1, stall=0, pc_we=1, ifid_we=1, idex_clr=0. stall_cnt does not increment.
6. Reset while md_busy=1 and stall_cnt=7 -> next cycle md_busy=0, stall_cnt=0. With CNT_W=4, 20 stalled cycles give stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew data hazards,
// MDU busy sequencing, exception flush and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [1:0]       tuse_rs_d,
  input  logic [1:0]       tuse_rt_d,
  input  logic             md_d,
  input  logic [4:0]       a_e,
  input  logic [1:0]       tnew_e,
  input  logic [4:0]       a_m,
  input  logic [1:0]       tnew_m,
  input  logic             md_start_e,
  input  logic             md_div_e,
  input  logic             exc_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_clr,
  output logic             req,
  output logic             md_busy,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned MD_W   = $clog2(MD_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [MD_W-1:0]  r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic            w_h_rs;
  logic            w_h_rt;
  logic            w_h_md;
  logic            w_req;
  logic            w_stall;
  logic [MD_W-1:0] w_md_load;

  always_comb begin
    w_h_rs = (rs_d != 5'd0) &&
             (((a_e == rs_d) && (tnew_e > tuse_rs_d)) ||
              ((a_m == rs_d) && (tnew_m > tuse_rs_d)));
    w_h_rt = (rt_d != 5'd0) &&
             (((a_e == rt_d) && (tnew_e > tuse_rt_d)) ||
              ((a_m == rt_d) && (tnew_m > tuse_rt_d)));
    w_h_md = md_d && (md_busy || md_start_e);
  end

  // A flush overrides any stall so the redirect to the exception vector is not held off.
  assign w_req   = exc_req & ~reset;
  assign w_stall = (w_h_rs | w_h_rt | w_h_md) & ~w_req & ~reset;

  assign req       = w_req;
  assign stall     = w_stall;
  assign pc_we     = ~w_stall;
  assign ifid_we   = ~w_stall;
  assign idex_clr  = w_stall;
  assign md_busy   = (r_md_cnt != '0);
  assign stall_cnt = r_stall_cnt;

  assign w_md_load = md_div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // An exception in the start cycle squashes the MDU op before it begins.
          if (md_start_e && !exc_req) begin
            r_md_cnt <= w_md_load;
            r_state  <= (w_md_load != '0) ? S_BUSY : S_IDLE;
          end
        end
        S_BUSY: begin
          r_md_cnt <= r_md_cnt - MD_W'(1);
          if (r_md_cnt <= MD_W'(1)) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_md_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
